// File: rtl/nrbd_nrsc_param.sv
// Non-restoring divide / square-root mantissa core for the div_sqrt FPU path.
// Produces up to MANT_W+2 root/quotient bits, ITER_PER_CYCLE radix-2 steps per clock.
module nrbd_nrsc_param #(
    parameter int MANT_W         = 23,
    parameter int EXP_W          = 8,
    parameter int BIAS           = 127,
    parameter int ITER_PER_CYCLE = 4,
    parameter int PREC_CTL_EN    = 1,
    parameter int PC_W           = 5
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Div_start_SI,
    input  logic              Sqrt_start_SI,
    input  logic              Kill_SI,
    input  logic [PC_W-1:0]   Precision_ctl_SI,
    input  logic [MANT_W:0]   Mant_a_DI,
    input  logic [MANT_W:0]   Mant_b_DI,
    input  logic [EXP_W:0]    Exp_a_DI,
    input  logic [EXP_W:0]    Exp_b_DI,
    input  logic              Out_ready_SI,
    output logic              Ready_SO,
    output logic              Busy_div_SO,
    output logic              Busy_sqrt_SO,
    output logic              Out_valid_SO,
    output logic [MANT_W+1:0] Mant_z_DO,
    output logic              Sticky_SO,
    output logic [EXP_W+1:0]  Exp_z_DO
);

    localparam int QW = MANT_W + 2;
    localparam int RW = MANT_W + 7;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(QW + ITER_PER_CYCLE + 1);
    localparam logic [CW-1:0] N_FULL   = CW'(QW);
    localparam logic [CW-1:0] N_STEP   = CW'(ITER_PER_CYCLE);
    localparam logic          BIAS_ODD = (BIAS % 2) != 0;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              op_div_q, op_div_d;
    logic [MANT_W:0]   a_q, a_d, b_q, b_d;
    logic [EXP_W:0]    ea_q, ea_d, eb_q, eb_d;
    logic [CW-1:0]     n_q, n_d, cnt_q, cnt_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [QW-1:0]     quo_q, quo_d;
    logic [EW-1:0]     exp_w_q, exp_w_d;
    logic              ready_q, ready_d, busy_div_q, busy_div_d, busy_sqrt_q, busy_sqrt_d;
    logic              out_valid_q, out_valid_d, sticky_q, sticky_d;
    logic [QW-1:0]     mant_z_q, mant_z_d;
    logic [EW-1:0]     exp_z_q, exp_z_d;

    // Requested digit count, clamped to [2, QW]; zero selects full precision.
    int unsigned   pc_i;
    logic [CW-1:0] n_req;
    always_comb begin
        pc_i = int'(Precision_ctl_SI);
        if (PREC_CTL_EN == 0 || pc_i == 0)
            n_req = N_FULL;
        else if (pc_i < 2)
            n_req = CW'(2);
        else if (pc_i > QW)
            n_req = N_FULL;
        else
            n_req = CW'(pc_i);
    end

    // Divisor in remainder units (2^-(MANT_W+1)).
    logic [RW-1:0] d_ext;
    assign d_ext = {{(RW-MANT_W-2){1'b0}}, b_q, 1'b0};

    // Radicand of an odd unbiased exponent is doubled so the exponent halves exactly.
    logic          sqrt_odd;
    logic [EW-1:0] ea_ext, e_adj, e_unb, exp_div, exp_sqrt;
    assign sqrt_odd = ea_q[0] ^ BIAS_ODD;
    assign ea_ext   = EW'(ea_q);
    assign e_adj    = sqrt_odd ? ea_ext - EW'(1) : ea_ext;
    assign e_unb    = e_adj - EW'(BIAS);
    assign exp_sqrt = EW'($signed(e_unb) >>> 1) + EW'(BIAS);
    assign exp_div  = ea_ext - EW'(eb_q) + EW'(BIAS);

    genvar gi;
    generate
        for (gi = 0; gi < ITER_PER_CYCLE; gi++) begin : g_stage
            logic [RW-1:0] r_in, r_out, r2, r_new, q2, one_k, term_sub, term_add;
            logic [QW-1:0] q_in, q_out;
            logic [CW-1:0] k;
            logic          active;
            if (gi == 0) begin : g_first
                assign r_in = rem_q;
                assign q_in = quo_q;
            end else begin : g_next
                assign r_in = g_stage[gi-1].r_out;
                assign q_in = g_stage[gi-1].q_out;
            end
            assign k      = cnt_q + CW'(gi);
            assign active = k < n_q;
            assign one_k  = {{(RW-1){1'b0}}, 1'b1} << (N_FULL - CW'(1) - k);
            assign q2     = {{(RW-QW-1){1'b0}}, q_in, 1'b0};
            // Negative remainder adds back; for sqrt the add-back also carries the retracted trial bit.
            assign term_sub = op_div_q ? d_ext : q2 + one_k;
            assign term_add = op_div_q ? d_ext : q2 + one_k + (one_k << 1);
            assign r2       = r_in << 1;
            assign r_new    = r_in[RW-1] ? r2 + term_add : r2 - term_sub;
            assign r_out    = active ? r_new : r_in;
            assign q_out    = (active && !r_new[RW-1]) ? (q_in | one_k[QW-1:0]) : q_in;
        end
    endgenerate

    logic [RW-1:0] r_fin, corr, one_last, rem_true;
    logic [QW-1:0] q_fin;
    logic          sticky_calc;
    assign r_fin       = g_stage[ITER_PER_CYCLE-1].r_out;
    assign q_fin       = g_stage[ITER_PER_CYCLE-1].q_out;
    assign one_last    = {{(RW-1){1'b0}}, 1'b1} << (N_FULL - n_q);
    assign corr        = op_div_q ? d_ext : {{(RW-QW-1){1'b0}}, q_fin, 1'b0} + one_last;
    assign rem_true    = r_fin[RW-1] ? r_fin + corr : r_fin;
    assign sticky_calc = |rem_true;

    always_comb begin
        state_d   = state_q;
        op_div_d  = op_div_q;
        a_d       = a_q;
        b_d       = b_q;
        ea_d      = ea_q;
        eb_d      = eb_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        exp_w_d   = exp_w_q;
        mant_z_d  = mant_z_q;
        sticky_d  = sticky_q;
        exp_z_d   = exp_z_q;
        if (Kill_SI && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Div_start_SI || Sqrt_start_SI) begin
                        state_d  = S_LOAD;
                        op_div_d = Div_start_SI;
                        a_d      = Mant_a_DI;
                        b_d      = Mant_b_DI;
                        ea_d     = Exp_a_DI;
                        eb_d     = Exp_b_DI;
                        n_d      = n_req;
                    end
                end
                S_LOAD: begin
                    // Remainder starts at half the dividend/radicand so every step is a uniform shift.
                    if (!op_div_q && sqrt_odd)
                        rem_d = {{(RW-MANT_W-2){1'b0}}, a_q, 1'b0};
                    else
                        rem_d = {{(RW-MANT_W-1){1'b0}}, a_q};
                    quo_d   = '0;
                    cnt_d   = '0;
                    exp_w_d = op_div_q ? exp_div : exp_sqrt;
                    state_d = S_ITER;
                end
                S_ITER: begin
                    rem_d = r_fin;
                    quo_d = q_fin;
                    cnt_d = cnt_q + N_STEP;
                    if (cnt_q + N_STEP >= n_q) begin
                        state_d  = S_DONE;
                        mant_z_d = q_fin;
                        sticky_d = sticky_calc;
                        exp_z_d  = exp_w_q;
                    end
                end
                S_DONE: begin
                    if (Out_ready_SI)
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        ready_d     = state_d == S_IDLE;
        out_valid_d = state_d == S_DONE;
        busy_div_d  = (state_d != S_IDLE) && op_div_d;
        busy_sqrt_d = (state_d != S_IDLE) && !op_div_d;
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q     <= S_IDLE;
            op_div_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            ea_q        <= '0;
            eb_q        <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            exp_w_q     <= '0;
            ready_q     <= 1'b1;
            busy_div_q  <= 1'b0;
            busy_sqrt_q <= 1'b0;
            out_valid_q <= 1'b0;
            mant_z_q    <= '0;
            sticky_q    <= 1'b0;
            exp_z_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_div_q    <= op_div_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            exp_w_q     <= exp_w_d;
            ready_q     <= ready_d;
            busy_div_q  <= busy_div_d;
            busy_sqrt_q <= busy_sqrt_d;
            out_valid_q <= out_valid_d;
            mant_z_q    <= mant_z_d;
            sticky_q    <= sticky_d;
            exp_z_q     <= exp_z_d;
        end
    end

    assign Ready_SO     = ready_q;
    assign Busy_div_SO  = busy_div_q;
    assign Busy_sqrt_SO = busy_sqrt_q;
    assign Out_valid_SO = out_valid_q;
    assign Mant_z_DO    = mant_z_q;
    assign Sticky_SO    = sticky_q;
    assign Exp_z_DO     = exp_z_q;

endmodule
